// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared types for the 5-stage MIPS core: machine word, register
//   number, the opaque execute/memory control bundle and the ID/EX
//   pipeline register layout, plus the MEM-stage bypass select.
package cpu_types_pkg;

    localparam int CTRL_W = 16;

    typedef logic [31:0]       word_t;
    typedef logic [4:0]        regbits_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    // Everything execute sees from decode, latched at the ID/EX boundary.
    typedef struct packed {
        logic     valid;
        logic     wen;
        logic     memread;
        regbits_t wsel;
        regbits_t rs;
        regbits_t rt;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        word_t    pc;
        ctrl_t    ctrl;
    } id_ex_t;

    // Selects the MEM-stage result over register file data when MEM is
    // writing the source register. r0 is hardwired to zero, so it never
    // takes a bypassed value.
    function automatic word_t mem_bypass(
        input word_t    rdat,
        input regbits_t src,
        input logic     mem_wen,
        input regbits_t mem_wsel,
        input word_t    mem_wdat
    );
        if (mem_wen && (mem_wsel != '0) && (mem_wsel == src))
            return mem_wdat;
        return rdat;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if
//   Port bundle for operand_fetch. Modport "of" is the block side,
//   modport "tb" is the driver/observer side (decode, register file,
//   MEM stage and execute as seen from outside).
interface operand_fetch_if;
    import cpu_types_pkg::*;

    logic     en, flush;
    logic     id_valid, id_wen, id_memread, id_ready;
    regbits_t id_rs, id_rt, id_wsel;
    word_t    id_imm, id_pc;
    ctrl_t    id_ctrl;
    regbits_t rsel1, rsel2;
    word_t    rdat1, rdat2;
    logic     mem_wen;
    regbits_t mem_wsel;
    word_t    mem_wdat;
    logic     ex_valid, ex_wen, ex_memread;
    regbits_t ex_wsel, ex_rs, ex_rt;
    word_t    ex_rdat1, ex_rdat2, ex_imm, ex_pc;
    ctrl_t    ex_ctrl;
    word_t    stall_count;

    modport of (
        input  en, flush, id_valid, id_rs, id_rt, id_wsel, id_wen, id_memread,
               id_imm, id_pc, id_ctrl, rdat1, rdat2, mem_wen, mem_wsel, mem_wdat,
        output id_ready, rsel1, rsel2, ex_valid, ex_wen, ex_memread, ex_wsel,
               ex_rs, ex_rt, ex_rdat1, ex_rdat2, ex_imm, ex_pc, ex_ctrl, stall_count
    );

    modport tb (
        output en, flush, id_valid, id_rs, id_rt, id_wsel, id_wen, id_memread,
               id_imm, id_pc, id_ctrl, rdat1, rdat2, mem_wen, mem_wsel, mem_wdat,
        input  id_ready, rsel1, rsel2, ex_valid, ex_wen, ex_memread, ex_wsel,
               ex_rs, ex_rt, ex_rdat1, ex_rdat2, ex_imm, ex_pc, ex_ctrl, stall_count
    );

endinterface

// File: rtl/hazard_unit.sv
// hazard_unit
//   Load-use hazard detection. A load sitting in ID/EX whose destination
//   matches either decode source forces one bubble; both sources are
//   compared even if the instruction ignores one of them.
//   Ports: ex_* (registered ID/EX fields), id_valid/id_rs/id_rt (decode),
//          en (global advance) -> hazard, id_ready.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     en,
    input  logic     id_valid,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     ex_valid,
    input  logic     ex_wen,
    input  logic     ex_memread,
    input  regbits_t ex_wsel,
    output logic     hazard,
    output logic     id_ready
);

    // hazard depends only on ID/EX state and decode fields, never on en.
    assign hazard = id_valid && ex_valid && ex_memread && ex_wen &&
                    (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

    assign id_ready = !hazard && en;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Decode-side operand fetch and ID/EX pipeline register.
//   - rsel1/rsel2 drive the register file read selects from id_rs/id_rt.
//   - Operands bypass the MEM-stage result (mem_wen/mem_wsel/mem_wdat);
//     writeback needs no bypass since the register file writes on the
//     falling edge and reads combinationally.
//   - Load-use hazards (hazard_unit) drop id_ready and insert a bubble,
//     counted in the saturating stall_count.
//   - en low freezes ID/EX and stall_count; flush squashes into a bubble.
//   Ports: CLK, nRST (async, active-low), decode id_*, register file
//          rsel/rdat, MEM-stage mem_*, ID/EX outputs ex_*, stall_count.
module operand_fetch
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  regbits_t          id_rs,
    input  regbits_t          id_rt,
    input  regbits_t          id_wsel,
    input  logic              id_wen,
    input  logic              id_memread,
    input  word_t             id_imm,
    input  word_t             id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              id_ready,
    output regbits_t          rsel1,
    output regbits_t          rsel2,
    input  word_t             rdat1,
    input  word_t             rdat2,
    input  logic              mem_wen,
    input  regbits_t          mem_wsel,
    input  word_t             mem_wdat,
    output logic              ex_valid,
    output logic              ex_wen,
    output logic              ex_memread,
    output regbits_t          ex_wsel,
    output regbits_t          ex_rs,
    output regbits_t          ex_rt,
    output word_t             ex_rdat1,
    output word_t             ex_rdat2,
    output word_t             ex_imm,
    output word_t             ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output word_t             stall_count
);

    id_ex_t idex_q;
    id_ex_t idex_load;
    id_ex_t idex_bubble;
    logic   hazard;

    assign rsel1 = id_rs;
    assign rsel2 = id_rt;

    hazard_unit u_hazard (
        .en         (en),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (idex_q.valid),
        .ex_wen     (idex_q.wen),
        .ex_memread (idex_q.memread),
        .ex_wsel    (idex_q.wsel),
        .hazard     (hazard),
        .id_ready   (id_ready)
    );

    // Normal load from decode, and the same value with its side-effecting
    // fields cleared for a bubble (remaining fields are don't-care).
    // NOTE: every always_comb output gets a full default first so no
    // path through the block can leave a latch behind.
    always_comb begin
        idex_load         = '0;
        idex_load.valid   = id_valid;
        idex_load.wen     = id_wen;
        idex_load.memread = id_memread;
        idex_load.wsel    = id_wsel;
        idex_load.rs      = id_rs;
        idex_load.rt      = id_rt;
        idex_load.rdat1   = mem_bypass(rdat1, id_rs, mem_wen, mem_wsel, mem_wdat);
        idex_load.rdat2   = mem_bypass(rdat2, id_rt, mem_wen, mem_wsel, mem_wdat);
        idex_load.imm     = id_imm;
        idex_load.pc      = id_pc;
        idex_load.ctrl    = id_ctrl;

        idex_bubble         = idex_load;
        idex_bubble.valid   = 1'b0;
        idex_bubble.wen     = 1'b0;
        idex_bubble.memread = 1'b0;
        idex_bubble.wsel    = '0;
        idex_bubble.ctrl    = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; nRST clears them asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_q      <= '0;
            stall_count <= '0;
        end else if (en) begin
            if (flush) begin
                // A squashed instruction is not stalled, so nothing is counted.
                idex_q <= idex_bubble;
            end else if (hazard) begin
                idex_q <= idex_bubble;
                if (stall_count != '1)
                    stall_count <= stall_count + 32'd1;
            end else begin
                idex_q <= idex_load;
            end
        end
    end

    assign ex_valid   = idex_q.valid;
    assign ex_wen     = idex_q.wen;
    assign ex_memread = idex_q.memread;
    assign ex_wsel    = idex_q.wsel;
    assign ex_rs      = idex_q.rs;
    assign ex_rt      = idex_q.rt;
    assign ex_rdat1   = idex_q.rdat1;
    assign ex_rdat2   = idex_q.rdat2;
    assign ex_imm     = idex_q.imm;
    assign ex_pc      = idex_q.pc;
    assign ex_ctrl    = idex_q.ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Directed testbench for operand_fetch: reset, basic latch, load-use
//   stall, MEM bypass, en hold, flush and asynchronous reset mid-stall.
module tb_operand_fetch;
    import cpu_types_pkg::*;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              en = 1'b1, flush = 1'b0;
    logic              id_valid = 1'b0, id_wen = 1'b0, id_memread = 1'b0;
    logic [4:0]        id_rs = '0, id_rt = '0, id_wsel = '0;
    logic [31:0]       id_imm = '0, id_pc = '0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic              id_ready;
    logic [4:0]        rsel1, rsel2;
    logic [31:0]       rdat1 = '0, rdat2 = '0;
    logic              mem_wen = 1'b0;
    logic [4:0]        mem_wsel = '0;
    logic [31:0]       mem_wdat = '0;
    logic              ex_valid, ex_wen, ex_memread;
    logic [4:0]        ex_wsel, ex_rs, ex_rt;
    logic [31:0]       ex_rdat1, ex_rdat2, ex_imm, ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       stall_count;

    int tests_run = 0;
    int tests_failed = 0;

    operand_fetch dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
        .id_wen(id_wen), .id_memread(id_memread), .id_imm(id_imm), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .id_ready(id_ready), .rsel1(rsel1), .rsel2(rsel2),
        .rdat1(rdat1), .rdat2(rdat2), .mem_wen(mem_wen), .mem_wsel(mem_wsel),
        .mem_wdat(mem_wdat), .ex_valid(ex_valid), .ex_wen(ex_wen),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic decode(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wsel, input logic wen, input logic mr,
                          input logic [31:0] d1, input logic [31:0] d2);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_wsel    = wsel;
        id_wen     = wen;
        id_memread = mr;
        rdat1      = d1;
        rdat2      = d2;
        id_imm     = {27'd0, wsel} + 32'h100;
        id_pc      = id_pc + 32'd4;
        id_ctrl    = 16'hA000 | {11'd0, wsel};
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        en   = 1'b1;
        decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        tests_run++;
        if ({ex_valid, ex_wen, ex_memread, ex_wsel, ex_rs, ex_rt} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_flags got v%b w%b m%b wsel%0d rs%0d rt%0d exp all 0",
                     ex_valid, ex_wen, ex_memread, ex_wsel, ex_rs, ex_rt);
        end
        tests_run++;
        if ({ex_rdat1, ex_rdat2, ex_imm, ex_pc, ex_ctrl} !== 144'd0) begin
            tests_failed++;
            $display("FAIL reset_data got %h %h %h %h %h exp 0", ex_rdat1, ex_rdat2, ex_imm, ex_pc, ex_ctrl);
        end
        tests_run++;
        if (stall_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_stall got %0d exp 0", stall_count);
        end
        tests_run++;
        if (id_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_id_ready got %b exp 1", id_ready);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_basic();
        // addu r3 = r1 + r2
        decode(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd5, 32'd7);
        #1;
        tests_run++;
        if (rsel1 !== 5'd1 || rsel2 !== 5'd2) begin
            tests_failed++;
            $display("FAIL basic_rsel got %0d/%0d exp 1/2", rsel1, rsel2);
        end
        step();
        tests_run++;
        if (ex_rdat1 !== 32'd5 || ex_rdat2 !== 32'd7) begin
            tests_failed++;
            $display("FAIL basic_rdat got %0d/%0d exp 5/7", ex_rdat1, ex_rdat2);
        end
        tests_run++;
        if (ex_wsel !== 5'd3 || ex_valid !== 1'b1 || ex_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ctl got wsel%0d v%b w%b exp wsel3 v1 w1", ex_wsel, ex_valid, ex_wen);
        end
        tests_run++;
        if (ex_ctrl !== 16'hA003 || ex_imm !== 32'h103 || ex_rs !== 5'd1 || ex_rt !== 5'd2) begin
            tests_failed++;
            $display("FAIL basic_fields got ctrl%h imm%h rs%0d rt%0d exp A003 103 1 2",
                     ex_ctrl, ex_imm, ex_rs, ex_rt);
        end
        tests_run++;
        if (stall_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_stall got %0d exp 0", stall_count);
        end
    endtask

    task automatic test_load_use();
        // lw r4, 0(r2)
        decode(1'b1, 5'd2, 5'd4, 5'd4, 1'b1, 1'b1, 32'h40, 32'd0);
        step();
        // addu r5 = r4 + r1
        decode(1'b1, 5'd4, 5'd1, 5'd5, 1'b1, 1'b0, 32'hBAD, 32'd9);
        #1;
        tests_run++;
        if (id_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL loaduse_ready got %b exp 0", id_ready);
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_wsel !== 5'd0 || ex_ctrl !== 16'd0) begin
            tests_failed++;
            $display("FAIL loaduse_bubble got v%b wsel%0d ctrl%h exp 0/0/0", ex_valid, ex_wsel, ex_ctrl);
        end
        tests_run++;
        if (stall_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL loaduse_stall got %0d exp 1", stall_count);
        end
        tests_run++;
        if (id_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL loaduse_ready_after got %b exp 1", id_ready);
        end
        // Load is now in MEM; its data arrives through the bypass.
        mem_wen  = 1'b1;
        mem_wsel = 5'd4;
        mem_wdat = 32'h55;
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_wsel !== 5'd5 || ex_rdat1 !== 32'h55 || ex_rdat2 !== 32'd9) begin
            tests_failed++;
            $display("FAIL loaduse_resume got v%b wsel%0d rd1 %h rd2 %h exp 1 5 55 9",
                     ex_valid, ex_wsel, ex_rdat1, ex_rdat2);
        end
        mem_wen = 1'b0;
    endtask

    task automatic test_bypass();
        mem_wen  = 1'b1;
        mem_wsel = 5'd4;
        mem_wdat = 32'hDEADBEEF;
        decode(1'b1, 5'd4, 5'd6, 5'd8, 1'b1, 1'b0, 32'd0, 32'd9);
        step();
        tests_run++;
        if (ex_rdat1 !== 32'hDEADBEEF || ex_rdat2 !== 32'd9) begin
            tests_failed++;
            $display("FAIL bypass_rs got %h/%h exp deadbeef/9", ex_rdat1, ex_rdat2);
        end
        mem_wsel = 5'd0;
        decode(1'b1, 5'd0, 5'd6, 5'd8, 1'b1, 1'b0, 32'h11, 32'd9);
        step();
        tests_run++;
        if (ex_rdat1 !== 32'h11) begin
            tests_failed++;
            $display("FAIL bypass_r0 got %h exp 11", ex_rdat1);
        end
        mem_wsel = 5'd6;
        decode(1'b1, 5'd1, 5'd6, 5'd8, 1'b1, 1'b0, 32'h22, 32'h33);
        step();
        tests_run++;
        if (ex_rdat1 !== 32'h22 || ex_rdat2 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_rt got %h/%h exp 22/deadbeef", ex_rdat1, ex_rdat2);
        end
        mem_wen = 1'b0;
        step();
        tests_run++;
        if (ex_rdat2 !== 32'h33) begin
            tests_failed++;
            $display("FAIL bypass_nowen got %h exp 33", ex_rdat2);
        end
    endtask

    task automatic test_enable_hold();
        // lw r7 into ID/EX
        decode(1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 32'h70, 32'd0);
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Dependent on r7, so the hazard condition is live throughout.
            decode(1'b1, 5'd7, 5'(i + 10), 5'(i + 20), 1'b1, 1'b0, 32'(i), 32'(i + 1));
            step();
            tests_run++;
            if (ex_valid !== 1'b1 || ex_memread !== 1'b1 || ex_wsel !== 5'd7 || ex_rdat1 !== 32'h70) begin
                tests_failed++;
                $display("FAIL hold_fields[%0d] got v%b m%b wsel%0d rd1 %h exp 1 1 7 70",
                         i, ex_valid, ex_memread, ex_wsel, ex_rdat1);
            end
            tests_run++;
            if (stall_count !== 32'd1 || id_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_stall[%0d] got cnt%0d rdy%b exp 1 0", i, stall_count, id_ready);
            end
        end
        en = 1'b1;
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || stall_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL hold_release got v%b cnt%0d exp 0 2", ex_valid, stall_count);
        end
    endtask

    task automatic test_flush();
        decode(1'b1, 5'd3, 5'd8, 5'd8, 1'b1, 1'b1, 32'h80, 32'd0);
        step();
        decode(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 32'd1, 32'd2);
        flush = 1'b1;
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_wen !== 1'b0 || stall_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL flush_hazard got v%b w%b cnt%0d exp 0 0 2", ex_valid, ex_wen, stall_count);
        end
        decode(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'd1, 32'd2);
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_wen !== 1'b0 || ex_ctrl !== 16'd0 || ex_wsel !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_plain got v%b w%b ctrl%h wsel%0d exp 0 0 0 0",
                     ex_valid, ex_wen, ex_ctrl, ex_wsel);
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        decode(1'b1, 5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 32'h90, 32'd0);
        step();
        decode(1'b1, 5'd9, 5'd9, 5'd11, 1'b1, 1'b0, 32'd1, 32'd2);
        step();
        // Load is stalled behind? No: bubble inserted, restore the load for a live stall.
        decode(1'b1, 5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 32'h90, 32'd0);
        step();
        decode(1'b1, 5'd9, 5'd9, 5'd11, 1'b1, 1'b0, 32'd1, 32'd2);
        #1;
        tests_run++;
        if (id_ready !== 1'b0 || stall_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL areset_pre got rdy%b cnt%0d exp 0 3", id_ready, stall_count);
        end
        #1;
        nRST = 1'b0;
        #1;
        tests_run++;
        if ({ex_valid, ex_wen, ex_memread, ex_wsel, ex_rdat1, ex_pc, ex_ctrl} !== 88'd0) begin
            tests_failed++;
            $display("FAIL areset_clear got v%b w%b m%b wsel%0d rd1 %h pc %h ctrl %h exp 0",
                     ex_valid, ex_wen, ex_memread, ex_wsel, ex_rdat1, ex_pc, ex_ctrl);
        end
        tests_run++;
        if (stall_count !== 32'd0 || id_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_stall got cnt%0d rdy%b exp 0 1", stall_count, id_ready);
        end
        @(negedge CLK);
        nRST = 1'b1;
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_wsel !== 5'd11 || ex_rdat1 !== 32'd1 || stall_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL areset_resume got v%b wsel%0d rd1 %h cnt%0d exp 1 11 1 0",
                     ex_valid, ex_wsel, ex_rdat1, stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_use();
        test_bypass();
        test_enable_hold();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
